// File: rtl/pcie_ntfy_pkg.sv
// pcie_ntfy_pkg
//   Shared definitions for the PCIe event-notification ring writer:
//   FSM state encoding, header field offsets, ring entry geometry and the
//   width of the drop statistic.
package pcie_ntfy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_COLLECT,
        ST_ISSUE,
        ST_DROP
    } ntfy_state_e;

    // Header word layout. The bucket field starts at bit 6. The interrupt
    // number sits directly above the bucket field, so its offset depends on
    // BUCKET_BITS and is derived in the top module.
    localparam int HDR_BUCKET_LSB = 6;
    localparam int HDR_OVF_BIT    = 31;

    // One ring entry is 16 bytes, which is four 32-bit event words.
    localparam int ENTRY_BYTES = 16;
    localparam int ENTRY_WORDS = ENTRY_BYTES / 4;

    localparam int STAT_W = 16;

endpackage

// File: rtl/pcie_ntfy_coalesce.sv
// pcie_ntfy_coalesce
//   Interrupt coalescer for one interrupt number. Only built when
//   PCIE_NTFY_COALESCE_EN is defined.
//   Completions accumulate in a pending counter. A timer runs while anything
//   is pending. The coalescer raises irq_o when the pending count reaches the
//   threshold (a threshold of 0 acts as 1) or when the timer expires; pending
//   and timer then restart. irq_o stays high until gnt_i.
// Ports:
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   cpl_i           one completion for this interrupt number
//   thr_i           coalescing threshold
//   gnt_i           the top has taken the pending interrupt
//   irq_o           an interrupt is waiting to be issued
`ifdef PCIE_NTFY_COALESCE_EN
module pcie_ntfy_coalesce #(
    parameter int THR_W        = 8,
    parameter int COAL_TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cpl_i,
    input  logic [THR_W-1:0] thr_i,
    input  logic             gnt_i,
    output logic             irq_o
);
    localparam int TMR_W = $clog2(COAL_TIMEOUT + 1);

    logic [15:0]      pend_q, pend_d, thr_eff;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             irq_q, irq_d, fire;

    always_comb begin
        thr_eff = (thr_i == '0) ? 16'd1 : 16'(thr_i);
        fire    = (pend_q != '0) &&
                  ((pend_q >= thr_eff) || (tmr_q == TMR_W'(COAL_TIMEOUT - 1)));
        pend_d  = pend_q;
        tmr_d   = tmr_q;
        irq_d   = irq_q;
        if (gnt_i) irq_d = 1'b0;
        if (fire) begin
            // A new event wins over a grant in the same cycle. A completion
            // arriving now opens the next window.
            irq_d  = 1'b1;
            pend_d = cpl_i ? 16'd1 : 16'd0;
            tmr_d  = '0;
        end else begin
            if (cpl_i && pend_q != 16'hFFFF) pend_d = pend_q + 16'd1;
            if (pend_q != '0) tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
            tmr_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            tmr_q  <= tmr_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule
`endif

// File: rtl/pcie_notify_ring_gen.sv
// pcie_notify_ring_gen
//   Event-notification writer. Each bucket owns a host-memory ring with a
//   64-bit programmable base and 2^RING_BITS entries of 16 B. Event packets
//   of up to four words are packed into one entry and issued as a memory
//   write (address and payload on separate handshakes). Write completions
//   become interrupts.
//   When a ring is full the block either stalls the input (DROP_ON_FULL=0)
//   or drops the packet and sets the bucket's overflow flag (DROP_ON_FULL=1).
//   The overflow flag is reported in bit 31 of the next written header.
//   Optional macro PCIE_NTFY_COALESCE_EN: per-interrupt-number coalescing by
//   threshold and timeout. Without the macro, every completion produces one
//   interrupt.
// Ports:
//   s_cfg_*  ring configuration (base, threshold); accepted only in IDLE
//   s_ack_*  host read-pointer updates (always accepted)
//   s_evd_*  event word stream (word 0 = header)
//   m_req_*  write request: address [63:4] and tag (interrupt number)
//   m_dat_*  write payload, 128-bit entry
//   s_cpl_*  write completions
//   m_int_*  interrupt output
//   stat_drop_o  saturating count of dropped packets
module pcie_notify_ring_gen
    import pcie_ntfy_pkg::*;
#(
    parameter int BUCKET_BITS  = 2,
    parameter int RING_BITS    = 8,
    parameter int INT_NUM_BITS = 2,
    parameter int DROP_ON_FULL = 0,
    parameter int COAL_TIMEOUT = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [BUCKET_BITS-1:0]    s_cfg_bucket_i,
    input  logic [64-(RING_BITS+4)-1:0] s_cfg_base_i,
    input  logic [RING_BITS-1:0]      s_cfg_thr_i,
    input  logic                      s_cfg_valid_i,
    output logic                      s_cfg_ready_o,
    input  logic [BUCKET_BITS-1:0]    s_ack_bucket_i,
    input  logic [RING_BITS:0]        s_ack_ptr_i,
    input  logic                      s_ack_valid_i,
    input  logic [31:0]               s_evd_data_i,
    input  logic                      s_evd_valid_i,
    input  logic                      s_evd_last_i,
    output logic                      s_evd_ready_o,
    output logic [59:0]               m_req_addr_o,
    output logic [INT_NUM_BITS-1:0]   m_req_tag_o,
    output logic                      m_req_valid_o,
    input  logic                      m_req_ready_i,
    output logic [127:0]              m_dat_data_o,
    output logic                      m_dat_valid_o,
    input  logic                      m_dat_ready_i,
    input  logic [INT_NUM_BITS-1:0]   s_cpl_tag_i,
    input  logic                      s_cpl_valid_i,
    output logic                      s_cpl_ready_o,
    output logic [INT_NUM_BITS-1:0]   m_int_data_o,
    output logic                      m_int_valid_o,
    input  logic                      m_int_ready_i,
    output logic [STAT_W-1:0]         stat_drop_o
);
    localparam int NB        = 1 << BUCKET_BITS;
    localparam int BASE_W    = 64 - (RING_BITS + 4);
    localparam int PTR_W     = RING_BITS + 1;
    localparam int INTNO_LSB = HDR_BUCKET_LSB + BUCKET_BITS;

    if (RING_BITS < 4 || RING_BITS > 12) begin : g_bad_ring_bits
        $error("RING_BITS must be in 4..12");
    end
    if (COAL_TIMEOUT < 1) begin : g_bad_timeout
        $error("COAL_TIMEOUT must be positive");
    end

    // Per-bucket register files.
    logic [BASE_W-1:0] base_q   [NB];
    logic [PTR_W-1:0]  wr_ptr_q [NB];
    logic [PTR_W-1:0]  ack_ptr_q[NB];
    logic [NB-1:0]     ovf_q;

    ntfy_state_e              state_q, state_d;
    logic [BUCKET_BITS-1:0]   bkt_q;
    logic [INT_NUM_BITS-1:0]  intno_q;
    logic [127:0]             ent_q;
    logic [2:0]               wcnt_q;
    logic                     req_done_q, dat_done_q;
    logic [STAT_W-1:0]        stat_q;

    logic             evd_fire, req_fire, dat_fire, cfg_fire;
    logic             issue_done, drop_done, ring_full;
    logic [PTR_W-1:0] occ;
    logic [31:0]      word;

    assign evd_fire = s_evd_valid_i && s_evd_ready_o;
    assign req_fire = m_req_valid_o && m_req_ready_i;
    assign dat_fire = m_dat_valid_o && m_dat_ready_i;
    assign cfg_fire = s_cfg_valid_i && s_cfg_ready_o;

    // Occupancy uses wrap-bit pointers, so a difference of exactly
    // 2^RING_BITS means the ring is full.
    assign occ       = wr_ptr_q[bkt_q] - ack_ptr_q[bkt_q];
    assign ring_full = (occ == {1'b1, {RING_BITS{1'b0}}});

    // Header bit 31 reports whether packets were dropped since the last write.
    assign word = (wcnt_q == '0) ? {ovf_q[bkt_q], s_evd_data_i[HDR_OVF_BIT-1:0]}
                                 : s_evd_data_i;

    always_comb begin
        state_d       = state_q;
        s_evd_ready_o = 1'b0;
        m_req_valid_o = 1'b0;
        m_dat_valid_o = 1'b0;
        issue_done    = 1'b0;
        drop_done     = 1'b0;
        case (state_q)
            ST_IDLE:   if (s_evd_valid_i) state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (!ring_full)             state_d = ST_COLLECT;
                else if (DROP_ON_FULL != 0) state_d = ST_DROP;
            end
            ST_COLLECT: begin
                s_evd_ready_o = 1'b1;
                if (evd_fire && s_evd_last_i) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                m_req_valid_o = !req_done_q;
                m_dat_valid_o = !dat_done_q;
                if ((req_done_q || req_fire) && (dat_done_q || dat_fire)) begin
                    issue_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_evd_ready_o = 1'b1;
                if (evd_fire && s_evd_last_i) begin
                    drop_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            bkt_q      <= '0;
            intno_q    <= '0;
            ent_q      <= '0;
            wcnt_q     <= '0;
            req_done_q <= 1'b0;
            dat_done_q <= 1'b0;
            stat_q     <= '0;
            ovf_q      <= '0;
            for (int i = 0; i < NB; i++) begin
                base_q[i]    <= '0;
                wr_ptr_q[i]  <= '0;
                ack_ptr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            // The header stays on the bus until COLLECT, so the routing
            // fields are taken from it while it waits in IDLE.
            if (state_q == ST_IDLE && s_evd_valid_i) begin
                bkt_q   <= s_evd_data_i[HDR_BUCKET_LSB +: BUCKET_BITS];
                intno_q <= s_evd_data_i[INTNO_LSB +: INT_NUM_BITS];
                ent_q   <= '0;
                wcnt_q  <= '0;
            end
            // Words past the fourth are accepted but not stored.
            if (state_q == ST_COLLECT && evd_fire && wcnt_q < 3'(ENTRY_WORDS)) begin
                ent_q[{wcnt_q[1:0], 5'd0} +: 32] <= word;
                wcnt_q <= wcnt_q + 3'd1;
            end
            if (req_fire) req_done_q <= 1'b1;
            if (dat_fire) dat_done_q <= 1'b1;
            if (issue_done) begin
                req_done_q       <= 1'b0;
                dat_done_q       <= 1'b0;
                wr_ptr_q[bkt_q]  <= wr_ptr_q[bkt_q] + PTR_W'(1);
                ovf_q[bkt_q]     <= 1'b0;
            end
            if (drop_done) begin
                ovf_q[bkt_q] <= 1'b1;
                if (stat_q != '1) stat_q <= stat_q + STAT_W'(1);
            end
            if (s_ack_valid_i) ack_ptr_q[s_ack_bucket_i] <= s_ack_ptr_i;
            // A config write comes after the ack, so it wins on the same bucket.
            if (cfg_fire) begin
                base_q[s_cfg_bucket_i]    <= s_cfg_base_i;
                wr_ptr_q[s_cfg_bucket_i]  <= '0;
                ack_ptr_q[s_cfg_bucket_i] <= '0;
                ovf_q[s_cfg_bucket_i]     <= 1'b0;
            end
        end
    end

    assign s_cfg_ready_o = (state_q == ST_IDLE);
    assign m_req_addr_o  = {base_q[bkt_q], wr_ptr_q[bkt_q][RING_BITS-1:0]};
    assign m_req_tag_o   = intno_q;
    assign m_dat_data_o  = ent_q;
    assign stat_drop_o   = stat_q;

    // Interrupt output register. It is shared by both completion schemes.
    logic                    int_vld_q, int_load;
    logic [INT_NUM_BITS-1:0] int_data_q, int_load_data;

`ifdef PCIE_NTFY_COALESCE_EN
    localparam int NI = 1 << INT_NUM_BITS;

    // One global threshold is loaded by every config write. Completions
    // carry only the interrupt number, not the bucket.
    logic [RING_BITS-1:0] thr_q;
    logic [NI-1:0]        irq_req, irq_gnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)      thr_q <= '0;
        else if (cfg_fire) thr_q <= s_cfg_thr_i;
    end

    for (genvar g = 0; g < NI; g++) begin : g_coal
        pcie_ntfy_coalesce #(
            .THR_W       (RING_BITS),
            .COAL_TIMEOUT(COAL_TIMEOUT)
        ) u_coal (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .cpl_i  (s_cpl_valid_i && (s_cpl_tag_i == INT_NUM_BITS'(g))),
            .thr_i  (thr_q),
            .gnt_i  (irq_gnt[g]),
            .irq_o  (irq_req[g])
        );
    end

    assign s_cpl_ready_o = 1'b1;

    // When the output slot is free, the lowest pending interrupt number
    // takes it.
    always_comb begin
        irq_gnt       = '0;
        int_load      = 1'b0;
        int_load_data = '0;
        if (!int_vld_q || m_int_ready_i) begin
            for (int i = NI - 1; i >= 0; i--) begin
                if (irq_req[i]) begin
                    irq_gnt       = '0;
                    irq_gnt[i]    = 1'b1;
                    int_load      = 1'b1;
                    int_load_data = INT_NUM_BITS'(i);
                end
            end
        end
    end
`else
    logic unused_thr;
    assign unused_thr    = ^s_cfg_thr_i;
    assign s_cpl_ready_o = !int_vld_q || m_int_ready_i;
    assign int_load      = s_cpl_valid_i && s_cpl_ready_o;
    assign int_load_data = s_cpl_tag_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            int_vld_q  <= 1'b0;
            int_data_q <= '0;
        end else if (int_load) begin
            int_vld_q  <= 1'b1;
            int_data_q <= int_load_data;
        end else if (m_int_ready_i) begin
            int_vld_q  <= 1'b0;
        end
    end

    assign m_int_valid_o = int_vld_q;
    assign m_int_data_o  = int_data_q;

endmodule

// File: tb/tb_pcie_notify_ring_gen.sv
module tb_pcie_notify_ring_gen;
    localparam int BB = 2, RB = 8, IB = 2, BW = 52;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Index 0: stall-on-full DUT, index 1: drop-on-full DUT.
    logic [BB-1:0]  cfg_bucket[2];
    logic [BW-1:0]  cfg_base  [2];
    logic [RB-1:0]  cfg_thr   [2];
    logic           cfg_valid [2], cfg_ready[2];
    logic [BB-1:0]  ack_bucket[2];
    logic [RB:0]    ack_ptr   [2];
    logic           ack_valid [2];
    logic [31:0]    evd_data  [2];
    logic           evd_valid [2], evd_last[2], evd_ready[2];
    logic [59:0]    req_addr  [2];
    logic [IB-1:0]  req_tag   [2];
    logic           req_valid [2], req_ready[2];
    logic [127:0]   dat_data  [2];
    logic           dat_valid [2], dat_ready[2];
    logic [IB-1:0]  cpl_tag   [2];
    logic           cpl_valid [2], cpl_ready[2];
    logic [IB-1:0]  int_data  [2];
    logic           int_valid [2], int_ready[2];
    logic [15:0]    stat_drop [2];

    pcie_notify_ring_gen #(.BUCKET_BITS(BB), .RING_BITS(RB), .INT_NUM_BITS(IB),
                           .DROP_ON_FULL(0), .COAL_TIMEOUT(1024)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_cfg_bucket_i(cfg_bucket[0]), .s_cfg_base_i(cfg_base[0]), .s_cfg_thr_i(cfg_thr[0]),
        .s_cfg_valid_i(cfg_valid[0]), .s_cfg_ready_o(cfg_ready[0]),
        .s_ack_bucket_i(ack_bucket[0]), .s_ack_ptr_i(ack_ptr[0]), .s_ack_valid_i(ack_valid[0]),
        .s_evd_data_i(evd_data[0]), .s_evd_valid_i(evd_valid[0]), .s_evd_last_i(evd_last[0]),
        .s_evd_ready_o(evd_ready[0]),
        .m_req_addr_o(req_addr[0]), .m_req_tag_o(req_tag[0]), .m_req_valid_o(req_valid[0]),
        .m_req_ready_i(req_ready[0]),
        .m_dat_data_o(dat_data[0]), .m_dat_valid_o(dat_valid[0]), .m_dat_ready_i(dat_ready[0]),
        .s_cpl_tag_i(cpl_tag[0]), .s_cpl_valid_i(cpl_valid[0]), .s_cpl_ready_o(cpl_ready[0]),
        .m_int_data_o(int_data[0]), .m_int_valid_o(int_valid[0]), .m_int_ready_i(int_ready[0]),
        .stat_drop_o(stat_drop[0])
    );

    pcie_notify_ring_gen #(.BUCKET_BITS(BB), .RING_BITS(RB), .INT_NUM_BITS(IB),
                           .DROP_ON_FULL(1), .COAL_TIMEOUT(1024)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_cfg_bucket_i(cfg_bucket[1]), .s_cfg_base_i(cfg_base[1]), .s_cfg_thr_i(cfg_thr[1]),
        .s_cfg_valid_i(cfg_valid[1]), .s_cfg_ready_o(cfg_ready[1]),
        .s_ack_bucket_i(ack_bucket[1]), .s_ack_ptr_i(ack_ptr[1]), .s_ack_valid_i(ack_valid[1]),
        .s_evd_data_i(evd_data[1]), .s_evd_valid_i(evd_valid[1]), .s_evd_last_i(evd_last[1]),
        .s_evd_ready_o(evd_ready[1]),
        .m_req_addr_o(req_addr[1]), .m_req_tag_o(req_tag[1]), .m_req_valid_o(req_valid[1]),
        .m_req_ready_i(req_ready[1]),
        .m_dat_data_o(dat_data[1]), .m_dat_valid_o(dat_valid[1]), .m_dat_ready_i(dat_ready[1]),
        .s_cpl_tag_i(cpl_tag[1]), .s_cpl_valid_i(cpl_valid[1]), .s_cpl_ready_o(cpl_ready[1]),
        .m_int_data_o(int_data[1]), .m_int_valid_o(int_valid[1]), .m_int_ready_i(int_ready[1]),
        .stat_drop_o(stat_drop[1])
    );

    int checks = 0, failures = 0;
    logic [31:0] pkt[8];

    // Write-side monitor: it records every request and payload handshake.
    int           req_cnt[2] = '{0, 0};
    int           dat_cnt[2] = '{0, 0};
    logic [59:0]  last_addr[2];
    logic [IB-1:0] last_tag[2];
    logic [127:0] last_dat[2];
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (req_valid[u] && req_ready[u]) begin
                req_cnt[u]++; last_addr[u] = req_addr[u]; last_tag[u] = req_tag[u];
            end
            if (dat_valid[u] && dat_ready[u]) begin
                dat_cnt[u]++; last_dat[u] = dat_data[u];
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic cfg(input int u, input logic [BB-1:0] b, input logic [BW-1:0] base);
        int n = 0;
        cfg_bucket[u] = b; cfg_base[u] = base; cfg_thr[u] = '0; cfg_valid[u] = 1'b1;
        @(negedge clk);
        while (!cfg_ready[u] && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (!cfg_ready[u]) begin
            failures++; $display("FAIL cfg_timeout u=%0d got ready=%b want 1", u, cfg_ready[u]);
        end
        @(posedge clk); #1 cfg_valid[u] = 1'b0;
    endtask

    task automatic ack(input int u, input logic [BB-1:0] b, input logic [RB:0] p);
        ack_bucket[u] = b; ack_ptr[u] = p; ack_valid[u] = 1'b1;
        @(posedge clk); #1 ack_valid[u] = 1'b0;
    endtask

    // Sends pkt[first..n-1]; the last one carries s_evd_last.
    task automatic send(input int u, input int first, input int n);
        int t;
        for (int i = first; i < n; i++) begin
            evd_data[u] = pkt[i]; evd_valid[u] = 1'b1; evd_last[u] = (i == n - 1);
            t = 0;
            @(negedge clk);
            while (!evd_ready[u] && t < 300) begin @(negedge clk); t++; end
            if (!evd_ready[u]) begin
                checks++; failures++;
                $display("FAIL send_timeout u=%0d word=%0d got ready=0 want 1", u, i);
                evd_valid[u] = 1'b0; evd_last[u] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        evd_valid[u] = 1'b0; evd_last[u] = 1'b0;
    endtask

    task automatic wait_wr(input int u, input int tgt);
        int t = 0;
        while ((req_cnt[u] < tgt || dat_cnt[u] < tgt) && t < 300) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (req_cnt[u] !== tgt || dat_cnt[u] !== tgt) begin
            failures++;
            $display("FAIL write_count u=%0d got req=%0d dat=%0d want %0d", u, req_cnt[u], dat_cnt[u], tgt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({cfg_ready[u], evd_ready[u], req_valid[u], dat_valid[u], int_valid[u], cpl_ready[u]} !== 6'b100001) begin
                failures++;
                $display("FAIL reset_ctrl u=%0d got %b want 100001", u,
                         {cfg_ready[u], evd_ready[u], req_valid[u], dat_valid[u], int_valid[u], cpl_ready[u]});
            end
            checks++;
            if (stat_drop[u] !== 16'd0) begin
                failures++; $display("FAIL reset_stat u=%0d got %h want 0000", u, stat_drop[u]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [2:0] rdy;
        int nb = req_cnt[0];
        cfg(0, 2'd1, 52'h12345);
        // Bucket 1, intno 2; the incoming bit 31 must be replaced by ovf=0.
        pkt[0] = 32'h8000_0240; pkt[1] = 32'hAAAA_1111; pkt[2] = 32'hBBBB_2222;
        evd_data[0] = pkt[0]; evd_valid[0] = 1'b1; evd_last[0] = 1'b0;
        @(negedge clk); rdy[2] = evd_ready[0];
        @(negedge clk); rdy[1] = evd_ready[0];
        @(negedge clk); rdy[0] = evd_ready[0];
        checks++;
        if (rdy !== 3'b001) begin
            failures++; $display("FAIL hdr_latency got %b want 001", rdy);
        end
        @(posedge clk); #1;
        send(0, 1, 3);
        @(negedge clk);
        checks++;
        if ({req_valid[0], dat_valid[0]} !== 2'b11) begin
            failures++; $display("FAIL issue_latency got %b want 11", {req_valid[0], dat_valid[0]});
        end
        wait_wr(0, nb + 1);
        checks++;
        if (last_addr[0] !== 60'h1234500 || last_tag[0] !== 2'd2) begin
            failures++; $display("FAIL basic_addr got %h/%0d want 1234500/2", last_addr[0], last_tag[0]);
        end
        checks++;
        if (last_dat[0] !== 128'h0000_0000_BBBB_2222_AAAA_1111_0000_0240) begin
            failures++; $display("FAIL basic_dat got %h want 00000000bbbb2222aaaa111100000240", last_dat[0]);
        end
        pkt[0] = 32'h0000_0140;
        send(0, 0, 1);
        wait_wr(0, nb + 2);
        checks++;
        if (last_addr[0] !== 60'h1234501 || last_dat[0] !== 128'h140 || last_tag[0] !== 2'd1) begin
            failures++; $display("FAIL basic_next got %h/%h/%0d want 1234501/140/1", last_addr[0], last_dat[0], last_tag[0]);
        end
    endtask

    task automatic test_long_packet();
        int nb = req_cnt[0];
        cfg(0, 2'd0, 52'hABCDE);
        pkt[0] = 32'h0; pkt[1] = 32'h1111_1111; pkt[2] = 32'h2222_2222;
        pkt[3] = 32'h3333_3333; pkt[4] = 32'h4444_4444; pkt[5] = 32'h5555_5555;
        send(0, 0, 6);
        wait_wr(0, nb + 1);
        checks++;
        if (last_dat[0] !== 128'h3333_3333_2222_2222_1111_1111_0000_0000 || last_addr[0] !== 60'hABCDE00) begin
            failures++; $display("FAIL long_pkt got %h @%h want 3333333322222222111111110 @abcde00", last_dat[0], last_addr[0]);
        end
        pkt[0] = 32'h0000_0300;
        send(0, 0, 1);
        wait_wr(0, nb + 2);
        checks++;
        if (last_dat[0] !== 128'h300 || last_addr[0] !== 60'hABCDE01 || last_tag[0] !== 2'd3) begin
            failures++; $display("FAIL after_long got %h @%h tag %0d want 300 @abcde01 tag 3", last_dat[0], last_addr[0], last_tag[0]);
        end
    endtask

    task automatic test_issue_stall();
        int nb = req_cnt[0];
        req_ready[0] = 1'b0;
        pkt[0] = 32'h0; pkt[1] = 32'hCAFE_F00D;
        send(0, 0, 2);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dat_cnt[0] !== nb + 1 || req_cnt[0] !== nb || req_valid[0] !== 1'b1 ||
            dat_valid[0] !== 1'b0 || evd_ready[0] !== 1'b0 || cfg_ready[0] !== 1'b0) begin
            failures++; $display("FAIL issue_wait got dat=%0d req=%0d rv=%b dv=%b want %0d %0d 1 0",
                                 dat_cnt[0], req_cnt[0], req_valid[0], dat_valid[0], nb + 1, nb);
        end
        checks++;
        if (req_addr[0] !== 60'hABCDE02) begin
            failures++; $display("FAIL issue_addr got %h want abcde02", req_addr[0]);
        end
        @(posedge clk); #1 req_ready[0] = 1'b1;
        wait_wr(0, nb + 1);
        pkt[0] = 32'h0;
        send(0, 0, 1);
        wait_wr(0, nb + 2);
        checks++;
        if (last_addr[0] !== 60'hABCDE03) begin
            failures++; $display("FAIL issue_ptr got %h want abcde03", last_addr[0]);
        end
    endtask

    task automatic test_cfg_ack_collision();
        int nb = req_cnt[0];
        @(negedge clk);
        cfg_bucket[0] = 2'd3; cfg_base[0] = 52'h33333; cfg_valid[0] = 1'b1;
        ack_bucket[0] = 2'd3; ack_ptr[0] = 9'h100; ack_valid[0] = 1'b1;
        @(posedge clk); #1 cfg_valid[0] = 1'b0; ack_valid[0] = 1'b0;
        // If the ack had won, the ring would read as full and stall here.
        pkt[0] = 32'h0000_00C0;
        send(0, 0, 1);
        wait_wr(0, nb + 1);
        checks++;
        if (last_addr[0] !== 60'h3333300) begin
            failures++; $display("FAIL cfg_ack_win got %h want 3333300", last_addr[0]);
        end
    endtask

    task automatic test_completion();
        int_ready[0] = 1'b0;
        cpl_tag[0] = 2'd3; cpl_valid[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (cpl_ready[0] !== 1'b1) begin
            failures++; $display("FAIL cpl_ready_idle got %b want 1", cpl_ready[0]);
        end
        @(posedge clk); #1 cpl_tag[0] = 2'd1;
        @(negedge clk);
        checks++;
        if ({int_valid[0], int_data[0], cpl_ready[0]} !== {1'b1, 2'd3, 1'b0}) begin
            failures++; $display("FAIL int_first got v=%b d=%0d r=%b want 1 3 0", int_valid[0], int_data[0], cpl_ready[0]);
        end
        @(posedge clk); #1 int_ready[0] = 1'b1;
        @(posedge clk); #1 cpl_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({int_valid[0], int_data[0]} !== {1'b1, 2'd1}) begin
            failures++; $display("FAIL int_second got v=%b d=%0d want 1 1", int_valid[0], int_data[0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (int_valid[0] !== 1'b0) begin
            failures++; $display("FAIL int_clear got %b want 0", int_valid[0]);
        end
    endtask

    task automatic test_full_stall();
        int nb, seen;
        cfg(0, 2'd2, 52'h22222);
        nb = req_cnt[0];
        pkt[0] = 32'h0000_0080;
        for (int i = 0; i < 256; i++) send(0, 0, 1);
        wait_wr(0, nb + 256);
        evd_data[0] = 32'h0000_0080; evd_valid[0] = 1'b1; evd_last[0] = 1'b1;
        seen = 0;
        repeat (20) begin @(negedge clk); if (evd_ready[0]) seen++; end
        checks++;
        if (seen !== 0 || req_cnt[0] !== nb + 256) begin
            failures++; $display("FAIL full_stall got ready_cycles=%0d writes=%0d want 0 %0d", seen, req_cnt[0] - nb, 256);
        end
        @(posedge clk); #1;
        ack(0, 2'd2, 9'h001);
        send(0, 0, 1);
        wait_wr(0, nb + 257);
        checks++;
        if (last_addr[0] !== 60'h2222200) begin
            failures++; $display("FAIL full_wrap got %h want 2222200", last_addr[0]);
        end
    endtask

    task automatic test_full_drop();
        cfg(1, 2'd2, 52'h22222);
        pkt[0] = 32'h0000_0080;
        for (int i = 0; i < 256; i++) send(1, 0, 1);
        wait_wr(1, 256);
        send(1, 0, 1);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (stat_drop[1] !== 16'd1 || req_cnt[1] !== 256) begin
            failures++; $display("FAIL drop_stat got stat=%0d writes=%0d want 1 256", stat_drop[1], req_cnt[1]);
        end
        ack(1, 2'd2, 9'h010);
        send(1, 0, 1);
        wait_wr(1, 257);
        checks++;
        if (last_dat[1][31:0] !== 32'h8000_0080 || last_addr[1] !== 60'h2222200) begin
            failures++; $display("FAIL drop_ovf_set got %h @%h want 80000080 @2222200", last_dat[1][31:0], last_addr[1]);
        end
        send(1, 0, 1);
        wait_wr(1, 258);
        checks++;
        if (last_dat[1][31:0] !== 32'h0000_0080 || last_addr[1] !== 60'h2222201) begin
            failures++; $display("FAIL drop_ovf_clr got %h @%h want 00000080 @2222201", last_dat[1][31:0], last_addr[1]);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            cfg_bucket[u] = '0; cfg_base[u] = '0; cfg_thr[u] = '0; cfg_valid[u] = 1'b0;
            ack_bucket[u] = '0; ack_ptr[u] = '0; ack_valid[u] = 1'b0;
            evd_data[u] = '0; evd_valid[u] = 1'b0; evd_last[u] = 1'b0;
            req_ready[u] = 1'b1; dat_ready[u] = 1'b1; int_ready[u] = 1'b1;
            cpl_tag[u] = '0; cpl_valid[u] = 1'b0;
        end
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_long_packet();
        test_issue_stall();
        test_cfg_ack_collision();
        test_completion();
        test_full_stall();
        test_full_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcie_notify_ring_gen.md
# pcie_notify_ring_gen

Parametrised event-notification writer for the PCIe DMA path. It gives each bucket a ring in host memory: the base address is 64-bit and programmable, and the ring depth is set by a parameter. Incoming event packets are packed into 16-byte ring entries and issued as memory-write requests to the downstream memwr engine. An interrupt is raised once each write completes, and an optional compile-time feature coalesces those interrupts. Full-ring handling is selectable between stall mode and drop-with-overflow-flag mode.

## Interface
- BUCKET_BITS, 2, log2 number of rings
- RING_BITS, 8, log2 entries per ring (entry = 16 B); range 4..12
- INT_NUM_BITS, 2, interrupt-number width
- DROP_ON_FULL, 0, 0 = stall input when ring full; 1 = drop packet and flag overflow
- COAL_TIMEOUT, 1024, coalescing timer in cycles (used only with the macro)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_cfg_bucket  in  BUCKET_BITS  ring to configure
- s_cfg_base  in  64-(RING_BITS+4)  ring base address, upper bits
- s_cfg_thr  in  RING_BITS  coalescing threshold
- s_cfg_valid / s_cfg_ready  in/out  1  config handshake
- s_ack_bucket  in  BUCKET_BITS  ring acknowledged by host
- s_ack_ptr  in  RING_BITS+1  host read pointer (wrap bit included)
- s_ack_valid  in  1  ack strobe (always accepted)
- s_evd_data  in  32  event word
- s_evd_valid / s_evd_last / s_evd_ready  in/in/out  1  event stream
- m_req_addr  out  60  write address [63:4]
- m_req_tag  out  INT_NUM_BITS  interrupt number
- m_req_valid / m_req_ready  out/in  1  request handshake
- m_dat_data  out  128  entry payload
- m_dat_valid / m_dat_ready  out/in  1  payload handshake
- s_cpl_tag  in  INT_NUM_BITS  tag of the completed write
- s_cpl_valid / s_cpl_ready  in/out  1  write-completion handshake
- m_int_data  out  INT_NUM_BITS  interrupt number
- m_int_valid / m_int_ready  out/in  1  interrupt handshake
- stat_drop  out  16  saturating count of dropped packets

## Operation
- Header word (word 0): bucket = [6+:BUCKET_BITS]; intno = [6+BUCKET_BITS+:INT_NUM_BITS]; bit 31 is overwritten with the bucket's ovf flag.
- A packet is at most 4 words. Words beyond the 4th are consumed and discarded. Unwritten lanes are zero.
- FSM states: IDLE, LOOKUP, COLLECT, ISSUE, DROP.
  - IDLE: on s_evd_valid, go to LOOKUP. s_evd_ready is 0.
  - LOOKUP: read wr_ptr[b] and ack_ptr[b].
    - full = (wr_ptr - ack_ptr) == 2^RING_BITS, computed modulo 2^(RING_BITS+1).
    - full and DROP_ON_FULL=0: stay in LOOKUP.
    - full and DROP_ON_FULL=1: go to DROP.
    - otherwise: go to COLLECT.
  - COLLECT: s_evd_ready=1. Pack words little-endian into the 128-bit lane. On last, go to ISSUE.
  - ISSUE:
    - m_req_addr = {base[b], wr_ptr[b][RING_BITS-1:0]}.
    - m_req_valid and m_dat_valid are driven independently; each drops after its own handshake.
    - When both have completed: wr_ptr[b]++ (wraps naturally), ovf[b] clears, go to IDLE.
  - DROP: consume the packet with s_evd_ready=1. Set ovf[b]=1. Increment stat_drop, saturating at 0xFFFF. Go to IDLE.
- Config:
  - s_cfg_ready = (state==IDLE).
  - A config write sets the base, resets wr_ptr[b] and ack_ptr[b] to 0, clears ovf[b], and loads the threshold.
- Ack: ack_ptr[b] <= s_ack_ptr. An ack and a config write to the same bucket in the same cycle: the config write wins.
- Completion (macro absent): s_cpl_ready = !m_int_valid || m_int_ready. Each completion loads m_int_data = s_cpl_tag and sets m_int_valid.

## Timing
- Reset values: all valids 0, s_evd_ready 0, s_cfg_ready 1, stat_drop 0. All pointers and ovf flags are 0. The FSM is in IDLE.
- Latency:
  - Header valid to first s_evd_ready: 2 cycles (IDLE→LOOKUP→COLLECT).
  - Last word accepted to m_req_valid: 1 cycle.
- Back-to-back packets: minimum gap is 2 cycles after the ISSUE handshakes.
- Valids, once asserted, hold with stable data until ready.
- Reset deasserted mid-packet: the remaining words are seen as a new header. Upstream resets in the same domain, so this is legal.

## Configuration
- Macro PCIE_NTFY_COALESCE_EN.
- Defined:
  - Each intno has a pending counter and a timer.
  - A completion increments pending. The timer starts when pending goes 0→1.
  - An interrupt fires when pending ≥ threshold (threshold 0 is treated as 1) or the timer reaches COAL_TIMEOUT. Pending and the timer then clear.
  - s_cpl_ready stays 1; completions arriving during a pending interrupt accumulate.
- Undefined: one interrupt per completion, as described under Operation.

## Structure
- Package pcie_ntfy_pkg: FSM state enum, header field offsets, entry size constant (16), stat width.
- Sub-module pcie_ntfy_coalesce: one instance per intno, compiled only under the macro.
- Per-bucket state is held in small register files; no RAM primitives.

## Test plan
- Configure bucket 1 with base 0x1_2345_0000 and RING_BITS=8. Send a 3-word packet → m_req_addr = 0x1_2345_000 ([63:4]); m_dat upper lane = 0; wr_ptr=1.
- Send 256 packets with no ack, DROP_ON_FULL=0 → the 257th header stalls (s_evd_ready=0). An ack with ptr=1 releases it, and it writes to entry 0 (wrapped).
- Same as above with DROP_ON_FULL=1 → the 257th packet is consumed and stat_drop=1. After an ack, the next entry's word 0 has bit31=1; the following entry has bit31=0.
- Send a 6-word packet → one 16-byte write holding words 0-3; words 4-5 are discarded; the next packet is unaffected.
- Macro on, threshold 4 → exactly one interrupt after the 4th completion. A single completion → an interrupt after 1024 cycles.
- Hold m_req_ready low for 10 cycles while m_dat is accepted immediately → the FSM waits in ISSUE; wr_ptr increments only after both handshakes.
